// File: rtl/ula_controle_serial.sv
// Bit-serial ALU with opcode decode: one result bit per cycle, LSB first; pronto 33 cycles after start (1 if invalid).
// No backpressure: inicio is ignored while ocupado, and operands are captured only on the start edge.
module ula_controle_serial (
    input  logic        clock,
    input  logic        reset,
    input  logic        inicio,
    input  logic [1:0]  aluOp,
    input  logic [5:0]  funct,
    input  logic [31:0] entradaA,
    input  logic [31:0] entradaB,
    output logic [0:3]  seletor,
    output logic [31:0] resultado,
    output logic        zero,
    output logic        ocupado,
    output logic        pronto,
    output logic        erro
);
    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_SLT = 4'd4;
    localparam logic [3:0] OP_NOR = 4'd5;

    typedef enum logic [1:0] {OCIOSO, CALCULA, FINALIZA} estado_t;

    estado_t     estado_q, estado_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [4:0]  cont_q, cont_d;
    logic        carry_q, carry_d;
    logic [31:0] resultado_q, resultado_d;
    logic        zero_q, zero_d;
    logic        pronto_q, pronto_d;
    logic        erro_q, erro_d;

    logic [3:0]  op_dec;
    logic        op_valido;
    logic        a_bit, b_bit, b_eff, soma, carry_out, bit_res;

    always_comb begin
        op_dec    = OP_ADD;
        op_valido = 1'b1;
        case (aluOp)
            2'b00: op_dec = OP_ADD;
            2'b01: op_dec = OP_SUB;
            2'b10: begin
                case (funct)
                    6'b100000: op_dec = OP_ADD;
                    6'b100010: op_dec = OP_SUB;
                    6'b100100: op_dec = OP_AND;
                    6'b100101: op_dec = OP_OR;
                    6'b100111: op_dec = OP_NOR;
                    6'b101010: op_dec = OP_SLT;
                    default:   op_valido = 1'b0;
                endcase
            end
            default: op_valido = 1'b0;
        endcase
    end

    // Subtraction-type ops add ~B with carry-in preloaded to 1.
    always_comb begin
        a_bit     = a_q[cont_q];
        b_bit     = b_q[cont_q];
        b_eff     = ((op_q == OP_SUB) || (op_q == OP_SLT)) ? ~b_bit : b_bit;
        soma      = a_bit ^ b_eff ^ carry_q;
        carry_out = (a_bit & b_eff) | (a_bit & carry_q) | (b_eff & carry_q);
        case (op_q)
            OP_AND:  bit_res = a_bit & b_bit;
            OP_OR:   bit_res = a_bit | b_bit;
            OP_NOR:  bit_res = ~(a_bit | b_bit);
            default: bit_res = soma;
        endcase
    end

    always_comb begin
        estado_d    = estado_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        cont_d      = cont_q;
        carry_d     = carry_q;
        resultado_d = resultado_q;
        zero_d      = 1'b0;
        pronto_d    = 1'b0;
        erro_d      = erro_q;
        case (estado_q)
            OCIOSO: begin
                if (inicio) begin
                    if (op_valido) begin
                        a_d      = entradaA;
                        b_d      = entradaB;
                        op_d     = op_dec;
                        cont_d   = 5'd0;
                        carry_d  = (op_dec == OP_SUB) || (op_dec == OP_SLT);
                        erro_d   = 1'b0;
                        estado_d = CALCULA;
                    end else begin
                        op_d        = OP_AND;
                        erro_d      = 1'b1;
                        resultado_d = 32'd0;
                        estado_d    = FINALIZA;
                    end
                end
            end
            CALCULA: begin
                resultado_d[cont_q] = bit_res;
                carry_d             = carry_out;
                cont_d              = cont_q + 5'd1;
                if (cont_q == 5'd31) begin
                    estado_d = FINALIZA;
                    // Signed less-than: sign of A-B corrected by overflow at bit 31.
                    if (op_q == OP_SLT)
                        resultado_d = {31'd0, soma ^ (carry_q ^ carry_out)};
                end
            end
            FINALIZA: begin
                pronto_d = 1'b1;
                zero_d   = (resultado_q == 32'd0);
                estado_d = OCIOSO;
            end
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q    <= OCIOSO;
            op_q        <= OP_AND;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            cont_q      <= 5'd0;
            carry_q     <= 1'b0;
            resultado_q <= 32'd0;
            zero_q      <= 1'b0;
            pronto_q    <= 1'b0;
            erro_q      <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cont_q      <= cont_d;
            carry_q     <= carry_d;
            resultado_q <= resultado_d;
            zero_q      <= zero_d;
            pronto_q    <= pronto_d;
            erro_q      <= erro_d;
        end
    end

    assign ocupado   = (estado_q != OCIOSO);
    assign seletor   = ocupado ? op_q : 4'd0;
    assign resultado = resultado_q;
    assign zero      = zero_q;
    assign pronto    = pronto_q;
    assign erro      = erro_q;
endmodule

// File: tb/tb_ula_controle_serial.sv
// Scoreboard bench for ula_controle_serial: driver queues expected responses, monitor checks each pronto pulse.
module tb_ula_controle_serial;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        inicio = 1'b0;
    logic [1:0]  aluOp = 2'b00;
    logic [5:0]  funct = 6'd0;
    logic [31:0] entradaA = 32'd0;
    logic [31:0] entradaB = 32'd0;
    logic [0:3]  seletor;
    logic [31:0] resultado;
    logic        zero, ocupado, pronto, erro;

    ula_controle_serial dut (
        .clock    (clock),
        .reset    (reset),
        .inicio   (inicio),
        .aluOp    (aluOp),
        .funct    (funct),
        .entradaA (entradaA),
        .entradaB (entradaB),
        .seletor  (seletor),
        .resultado(resultado),
        .zero     (zero),
        .ocupado  (ocupado),
        .pronto   (pronto),
        .erro     (erro)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        erro;
        logic [3:0]  sel;
        int          lat;
        int          start;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;
    int   n_done = 0;
    int   occ_cnt = 0;
    int   unexpected = 0;
    int   zero_idle = 0;
    logic sel_bad = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        else
            passed++;
    endtask

    // Monitor: tracks the busy window, then scores each completion pulse.
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            occ_cnt = 0;
            sel_bad = 1'b0;
        end else begin
            if (ocupado) begin
                occ_cnt++;
                if (q.size() > 0 && seletor != q[0].sel) sel_bad = 1'b1;
            end
            if (!pronto && zero) zero_idle++;
            if (pronto) begin
                if (q.size() == 0) begin
                    unexpected++;
                    $display("FAIL unexpected_pronto at cycle %0d", cyc);
                end else begin
                    e = q.pop_front();
                    check("resultado", resultado, e.res);
                    check("zero", zero, e.zero);
                    check("erro", erro, e.erro);
                    check("latency", cyc - e.start, e.lat);
                    check("ocupado_cycles", occ_cnt, e.lat);
                    check("seletor_stable", sel_bad, 1'b0);
                end
                occ_cnt = 0;
                sel_bad = 1'b0;
                n_done++;
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res, input logic z,
                         input logic er, input logic [3:0] sel, input int lat);
        exp_t e;
        @(negedge clock);
        aluOp    = op;
        funct    = fn;
        entradaA = a;
        entradaB = b;
        inicio   = 1'b1;
        e.res = res; e.zero = z; e.erro = er; e.sel = sel; e.lat = lat; e.start = cyc + 1;
        q.push_back(e);
        @(negedge clock);
        inicio = 1'b0;
    endtask

    task automatic wait_done(input int d0, input logic [31:0] res);
        bit got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clock);
            #1;
            if (n_done != d0) got = 1'b1;
        end
        if (!got) begin
            checks++;
            $display("FAIL timeout: no pronto within 60 cycles (cycle %0d)", cyc);
            q.delete();
        end
        repeat (2) @(negedge clock);
        #1;
        check("resultado_hold", resultado, res);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] res, input logic z,
                          input logic er, input logic [3:0] sel, input int lat);
        int d0 = n_done;
        issue(op, fn, a, b, res, z, er, sel, lat);
        wait_done(d0, res);
    endtask

    initial begin
        int d0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        check("reset_resultado", resultado, 32'd0);
        check("reset_flags", {zero, pronto, erro, ocupado}, 4'b0000);
        check("reset_seletor", seletor, 4'd0);

        //      aluOp  funct      A             B             result        z     erro  sel lat
        run_op(2'b00, 6'd0,      32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 2, 33);
        run_op(2'b01, 6'd0,      32'd5,        32'd5,        32'h00000000, 1'b1, 1'b0, 3, 33);
        run_op(2'b01, 6'd0,      32'd0,        32'd1,        32'hFFFFFFFF, 1'b0, 1'b0, 3, 33);
        run_op(2'b10, 6'b101010, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 4, 33);
        run_op(2'b10, 6'b101010, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 4, 33);
        run_op(2'b10, 6'b101010, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b1, 1'b0, 4, 33);
        run_op(2'b10, 6'b101010, 32'd3,        32'd3,        32'h00000000, 1'b1, 1'b0, 4, 33);
        run_op(2'b10, 6'b100100, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 0, 33);
        run_op(2'b10, 6'b100101, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0, 1, 33);
        run_op(2'b10, 6'b100111, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 1'b0, 1'b0, 5, 33);
        run_op(2'b10, 6'b100000, 32'd1,        32'd2,        32'h00000003, 1'b0, 1'b0, 2, 33);
        run_op(2'b10, 6'b100010, 32'd10,       32'd3,        32'h00000007, 1'b0, 1'b0, 3, 33);
        run_op(2'b10, 6'b000000, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1'b1, 0, 1);
        run_op(2'b11, 6'b100000, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1'b1, 0, 1);
        // erro must clear on the following valid start
        run_op(2'b00, 6'd0,      32'd100,      32'd23,       32'd123,      1'b0, 1'b0, 2, 33);

        // Second start while busy must be ignored
        d0 = n_done;
        issue(2'b00, 6'd0, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0, 2, 33);
        repeat (8) @(negedge clock);
        aluOp = 2'b01; entradaA = 32'd100; entradaB = 32'd1; inicio = 1'b1;
        @(negedge clock);
        inicio = 1'b0; entradaA = 32'd0; entradaB = 32'd0;
        wait_done(d0, 32'd30);

        // Reset mid-calculation aborts without a completion pulse
        issue(2'b00, 6'd0, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, 2, 33);
        repeat (13) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        q.delete();
        #1;
        check("abort_resultado", resultado, 32'd0);
        check("abort_flags", {zero, pronto, erro, ocupado}, 4'b0000);
        check("abort_seletor", seletor, 4'd0);
        repeat (40) @(negedge clock);
        check("no_pronto_after_reset", unexpected, 0);

        run_op(2'b00, 6'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 2, 33);

        check("zero_low_when_idle", zero_idle, 0);
        check("scoreboard_empty", q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/ula_controle_serial.md
ULA_CONTROLE_SERIAL -- requirements
Module: ula_controle_serial

Interface
REQ-001 SHALL have port `clock`, input, 1 bit: single clock, all state updates on rising edge.
REQ-002 SHALL have port `reset`, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port `inicio`, input, 1 bit: start request, sampled only in OCIOSO.
REQ-004 SHALL have port `aluOp`, input, 2 bits: main-control operation class.
REQ-005 SHALL have port `funct`, input, 6 bits: R-type function field.
REQ-006 SHALL have ports `entradaA` and `entradaB`, input, 32 bits each: operands, latched at start.
REQ-007 SHALL have port `seletor`, output, 4 bits, declared [0:3]: operation code presented to the 1-bit ULA slice.
REQ-008 SHALL have port `resultado`, output, 32 bits: registered result.
REQ-009 SHALL have port `zero`, output, 1 bit: resultado == 0, valid with pronto.
REQ-010 SHALL have port `ocupado`, output, 1 bit: high whenever state != OCIOSO.
REQ-011 SHALL have port `pronto`, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port `erro`, output, 1 bit: invalid operation flag, valid with pronto.

Function
REQ-013 SHALL use seletor codes AND=0, OR=1, ADD=2, SUB=3, SLT=4, NOR=5; codes 6-15 SHALL never be driven.
REQ-014 SHALL decode the operation as follows.
- aluOp 00 -> ADD.
- aluOp 01 -> SUB.
- aluOp 10 with funct 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100111 NOR, 101010 SLT.
- Any other aluOp/funct combination -> invalid.
REQ-015 SHALL implement FSM states OCIOSO, CALCULA, FINALIZA.
REQ-016 In OCIOSO with inicio=1 and a valid operation, the block SHALL perform all of the following on that edge.
- Latch entradaA, entradaB and the decoded operation.
- Clear the bit counter to 0.
- Load carry with 1 for SUB/SLT, 0 otherwise.
- Go to CALCULA.
REQ-017 In OCIOSO with inicio=1 and an invalid operation, the block SHALL set erro=1, clear resultado to 0 and go to FINALIZA.
REQ-018 In CALCULA, the block SHALL process one bit per cycle, LSB first, for bit index i = counter 0..31.
- B' = B for ADD; B' = ~B for SUB/SLT.
- AND/OR/NOR are computed bitwise.
- ADD/SUB/SLT sum bit = A[i]^B'[i]^carry; carry updated to the majority of the three.
REQ-019 The bit computed at index i SHALL be written to resultado[i]; bits not yet processed SHALL hold their previous value.
REQ-020 After processing i=31, the block SHALL go to FINALIZA.
- For SLT, resultado SHALL become {31'b0, s31 ^ ovf}, where s31 is the sign bit of A-B and ovf = carry-into-bit31 XOR carry-out-of-bit31.
- ADD/SUB overflow SHALL be ignored (wrap modulo 2^32).
REQ-021 In FINALIZA, the block SHALL assert pronto=1 for exactly one cycle, with zero = (resultado == 0) and erro valid, then return to OCIOSO.
- erro SHALL clear on the next start.
REQ-022 Latency SHALL be as follows.
- Valid operation: inicio sampled at edge t -> pronto high in the cycle after edge t+33; ocupado high for 33 cycles.
- Invalid operation: pronto one cycle after the start edge.
REQ-023 seletor SHALL equal the latched operation code while ocupado=1 and 0 in OCIOSO.
REQ-024 inicio while ocupado=1 SHALL be ignored; operand inputs SHALL NOT be sampled after start.
REQ-025 resultado SHALL hold its value in OCIOSO until the next start.
REQ-026 zero SHALL be meaningful only while pronto=1 and SHALL be held low otherwise.

Reset
REQ-027 While reset=1 at a clock edge, the block SHALL go to OCIOSO with counter=0, carry=0, resultado=0, zero=0, pronto=0, erro=0, ocupado=0, seletor=0.
REQ-028 Reset during CALCULA or FINALIZA SHALL abort the operation; no pronto pulse SHALL follow.
REQ-029 reset SHALL take priority over inicio on the same edge.

Verification
REQ-030 The bench SHALL cover ADD wrap and latency: aluOp=00, A=0x7FFFFFFF, B=1 -> resultado 0x80000000, zero=0, erro=0, pronto exactly 33 cycles after the start edge, seletor=2 throughout.
REQ-031 The bench SHALL cover SUB: aluOp=01, A=B=5 -> resultado 0, zero=1; A=0, B=1 -> 0xFFFFFFFF.
REQ-032 The bench SHALL cover SLT: funct 101010.
- A=0xFFFFFFFF, B=1 -> 1.
- A=0x80000000, B=0x7FFFFFFF (overflow case) -> 1.
- A=0x7FFFFFFF, B=0x80000000 -> 0.
- A=B=3 -> 0 with zero=1.
REQ-033 The bench SHALL cover logic ops: A=0xF0F0F0F0, B=0xFF00FF00 -> AND 0xF000F000, OR 0xFFF0FFF0, NOR 0x000F000F.
REQ-034 The bench SHALL cover invalid operation: aluOp=10, funct=000000 -> pronto on the next cycle with erro=1, resultado=0; aluOp=11 gives the same response.
REQ-035 The bench SHALL cover busy and reset handling.
- A second inicio with different operands at cycle 10 of an ADD SHALL be ignored; the original result SHALL be returned.
- reset asserted at cycle 15 SHALL return all outputs to zero, with no pronto afterwards.
- A new start after reset SHALL complete normally.
